br_lite_local_if: RTL and testbench
===================================

Name: br_lite_local_if

Overview:
- Local-port network interface between a PE and the BrLite router's BR_LOCAL port.
- TX side: takes PE broadcast requests and builds full br_data_t flits, stamping seq_source and id. Drives the router's local input with the req/ack handshake and honours the router's local_busy.
- RX side: accepts flits delivered on the router's local output with req/ack, buffers them in a FIFO, and presents them to the PE through a valid/ready interface.

Parameters:
- SEQ_ADDRESS, 16'h0000, sequential address of this PE; written into seq_source of every transmitted flit.
- RX_DEPTH, 4, RX FIFO depth in flits; power of 2, at least 2.

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  reset, synchronous, active-high.
- tx_valid_i  in  1  PE has a request.
- tx_ready_o  out  1  request accepted this cycle when tx_valid_i is high.
- tx_service_i  in  width of br_data_t.service  requested service.
- tx_target_i  in  width of br_data_t.seq_target  target sequential address.
- tx_payload_i  in  width of br_data_t.payload  payload.
- tx_err_o  out  1  one-cycle pulse: request rejected.
- local_busy_i  in  1  router local_busy_o.
- flit_o  out  br_data_t  to router flit_i[BR_LOCAL].
- req_o  out  1  to router req_i[BR_LOCAL].
- ack_i  in  1  from router ack_o[BR_LOCAL].
- flit_i  in  br_data_t  from router flit_o[BR_LOCAL].
- req_i  in  1  from router req_o[BR_LOCAL].
- ack_o  out  1  to router ack_i[BR_LOCAL].
- rx_valid_o  out  1  FIFO not empty.
- rx_ready_i  in  1  PE pops the head flit when high with rx_valid_o.
- rx_flit_o  out  br_data_t  FIFO head; valid only while rx_valid_o is high.
- rx_count_o  out  $clog2(RX_DEPTH)+1  FIFO occupancy.

Behaviour:

Reset (rst_i sampled high at clk_i edge):
- All outputs are 0: req_o, ack_o, tx_err_o, rx_valid_o, rx_count_o, flit_o.
- TX FSM goes to TX_IDLE, RX FSM goes to RX_IDLE, FIFO is emptied, id counter is cleared to 0.
- Reset mid-handshake abandons the flit; req_o and ack_o are low from the next cycle.

TX FSM, states TX_IDLE and TX_REQ:
- tx_ready_o = (state == TX_IDLE) && !local_busy_i. This is combinational.
- On accept (tx_valid_i && tx_ready_o):
  - If tx_service_i == BR_SVC_CLEAR: tx_err_o pulses in the next cycle, nothing is sent, the id counter is unchanged, and the FSM stays in TX_IDLE.
  - Otherwise: flit_o is registered as {seq_source = SEQ_ADDRESS, seq_target = tx_target_i, service = tx_service_i, payload = tx_payload_i, id = id_cnt}. id_cnt increments and wraps modulo the id field width. The FSM goes to TX_REQ.
- TX_REQ:
  - req_o = 1 and flit_o is held stable.
  - When ack_i is sampled 1, the FSM returns to TX_IDLE and req_o is 0 in the following cycle. This deassertion is mandatory, so the router's IN_INIT does not re-arbitrate the same flit.
- ack_i seen in TX_IDLE is ignored.
- Only one flit is outstanding at a time. The router raises local_busy before it acks, so the next accept waits for the router's clear to finish.
- flit_o keeps its last value in TX_IDLE.

RX FSM, states RX_IDLE, RX_ACK and RX_DRAIN:
- RX_IDLE:
  - If req_i is high and the FIFO is not full, flit_i is written to the FIFO and the FSM goes to RX_ACK.
  - If the FIFO is full, no ack is given and the router stalls with req_i held.
- RX_ACK: ack_o = 1 for exactly one cycle, then the FSM goes to RX_DRAIN.
- RX_DRAIN: the FSM waits for req_i == 0, then returns to RX_IDLE. A flit is never captured twice.
- ack_o is 0 in every other state.
- Capture-to-ack latency is 1 cycle.

FIFO:
- Circular buffer; pointers wrap modulo RX_DEPTH.
- A same-cycle push and pop are both performed and rx_count_o is unchanged. A push while full never occurs.
- rx_flit_o and rx_valid_o update the cycle after the write.
- rx_count_o ranges from 0 to RX_DEPTH.

Test Plan:
1. Reset, then a TX request: tgt=5, svc=BR_SVC_TGT, payload=0xABCD, SEQ_ADDRESS=3.
   - The next cycle has req_o=1, flit_o.seq_source=3, id=0.
   - The router model acks 2 cycles later; req_o is 0 in the cycle after the ack is sampled.
   - A second request gets id=1.
2. Hold local_busy_i=1 while tx_valid_i=1.
   - tx_ready_o stays 0 and no req_o is raised.
   - Drop busy; the request is accepted the same cycle.
3. Request with tx_service_i=BR_SVC_CLEAR.
   - tx_err_o pulses one cycle, req_o stays 0, and the id counter is unchanged.
4. Router model presents 4 flits with RX_DEPTH=4 and rx_ready_i=0.
   - Each gets one ack_o pulse; rx_count_o reaches 4.
   - A 5th req_i stays unacked.
   - Pop one; ack_o follows, and FIFO order is preserved across pointer wrap.
5. Simultaneous push and pop at count=2 leaves rx_count_o=2. The id counter wraps from its maximum to 0 after 2^width sends.
6. Assert rst_i while req_o=1 and during RX_ACK.
   - The next cycle has req_o=0, ack_o=0, rx_count_o=0, and the next id is 0.

Source files
------------

// File: rtl/br_lite_local_if.sv
// br_lite_local_if -- local-port network interface between a PE and the
// BrLite router's BR_LOCAL port.
//
// TX: PE requests (valid/ready) are turned into full br_data_t flits that
//     carry this PE's sequential address and a running id. Each flit is sent
//     to the router with req/ack. Only one flit is outstanding at a time.
// RX: Flits from the router's local output are captured with req/ack into a
//     small circular FIFO. The FIFO head is offered to the PE over valid/ready.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   tx_valid_i/tx_ready_o   PE request handshake (ready is combinational)
//   tx_service_i/target/payload  request contents
//   tx_err_o                one-cycle pulse when a CLEAR request is rejected
//   local_busy_i            router local_busy; blocks new requests
//   flit_o/req_o/ack_i      flit towards the router local input
//   flit_i/req_i/ack_o      flit from the router local output
//   rx_valid_o/rx_ready_i   PE receive handshake
//   rx_flit_o               FIFO head (valid only with rx_valid_o)
//   rx_count_o              FIFO occupancy, 0..RX_DEPTH

package br_lite_pkg;
  localparam int BR_ADDR_W    = 16;
  localparam int BR_PAYLOAD_W = 32;
  localparam int BR_ID_W      = 5;

  typedef enum logic [1:0] {
    BR_SVC_ALL   = 2'd0,
    BR_SVC_TGT   = 2'd1,
    BR_SVC_CLEAR = 2'd2
  } br_service_t;

  localparam int BR_SVC_W = $bits(br_service_t);

  typedef struct packed {
    logic [BR_ADDR_W-1:0]    seq_source;
    logic [BR_ADDR_W-1:0]    seq_target;
    br_service_t             service;
    logic [BR_PAYLOAD_W-1:0] payload;
    logic [BR_ID_W-1:0]      id;
  } br_data_t;
endpackage

module br_lite_local_if
  import br_lite_pkg::*;
#(
  parameter logic [BR_ADDR_W-1:0] SEQ_ADDRESS = 16'h0000,
  parameter int unsigned          RX_DEPTH    = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  // PE transmit side
  input  logic                      tx_valid_i,
  output logic                      tx_ready_o,
  input  logic [BR_SVC_W-1:0]       tx_service_i,
  input  logic [BR_ADDR_W-1:0]      tx_target_i,
  input  logic [BR_PAYLOAD_W-1:0]   tx_payload_i,
  output logic                      tx_err_o,
  // router local input
  input  logic                      local_busy_i,
  output br_data_t                  flit_o,
  output logic                      req_o,
  input  logic                      ack_i,
  // router local output
  input  br_data_t                  flit_i,
  input  logic                      req_i,
  output logic                      ack_o,
  // PE receive side
  output logic                      rx_valid_o,
  input  logic                      rx_ready_i,
  output br_data_t                  rx_flit_o,
  output logic [$clog2(RX_DEPTH):0] rx_count_o
);

  localparam int PTR_W = $clog2(RX_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // ---------------------------------------------------------------- TX ----
  typedef enum logic {TX_IDLE, TX_REQ} tx_state_t;
  tx_state_t tx_state_q, tx_state_d;

  logic [BR_ID_W-1:0] id_cnt_q;
  logic               tx_accept;
  logic               tx_is_clear;
  logic               tx_send;

  assign tx_ready_o  = (tx_state_q == TX_IDLE) && !local_busy_i;
  assign tx_accept   = tx_valid_i && tx_ready_o;
  assign tx_is_clear = (tx_service_i == BR_SVC_CLEAR);
  assign tx_send     = tx_accept && !tx_is_clear;
  assign req_o       = (tx_state_q == TX_REQ);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, matching real flip-flops.
  always_ff @(posedge clk_i) begin
    if (rst_i) tx_state_q <= TX_IDLE;
    else       tx_state_q <= tx_state_d;
  end

  // NOTE: the default assigned first covers every path through the case,
  // so no latch is inferred for the next-state signal.
  always_comb begin
    tx_state_d = tx_state_q;
    case (tx_state_q)
      TX_IDLE: if (tx_send) tx_state_d = TX_REQ;
      // Dropping req right after the ack keeps the router from
      // re-arbitrating the same flit.
      TX_REQ:  if (ack_i)   tx_state_d = TX_IDLE;
      default:              tx_state_d = TX_IDLE;
    endcase
  end

  // Flit register is written only on a real send, so it holds its last
  // value while idle; id wraps naturally at the field width.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flit_o   <= '0;
      id_cnt_q <= '0;
      tx_err_o <= 1'b0;
    end else begin
      tx_err_o <= tx_accept && tx_is_clear;
      if (tx_send) begin
        flit_o   <= '{seq_source: SEQ_ADDRESS,
                      seq_target: tx_target_i,
                      service:    br_service_t'(tx_service_i),
                      payload:    tx_payload_i,
                      id:         id_cnt_q};
        id_cnt_q <= id_cnt_q + BR_ID_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------- RX ----
  typedef enum logic [1:0] {RX_IDLE, RX_ACK, RX_DRAIN} rx_state_t;
  rx_state_t rx_state_q, rx_state_d;

  br_data_t           mem_q [RX_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               fifo_full;
  logic               push;
  logic               pop;

  assign fifo_full  = (count_q == CNT_W'(RX_DEPTH));
  // A full FIFO withholds the capture, so the router stalls with req held.
  assign push       = (rx_state_q == RX_IDLE) && req_i && !fifo_full;
  assign pop        = rx_valid_o && rx_ready_i;
  assign ack_o      = (rx_state_q == RX_ACK);
  assign rx_valid_o = (count_q != '0);
  assign rx_flit_o  = mem_q[rd_ptr_q];
  assign rx_count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) rx_state_q <= RX_IDLE;
    else       rx_state_q <= rx_state_d;
  end

  // RX_DRAIN waits for the router to drop req so one request is never
  // captured twice.
  always_comb begin
    rx_state_d = rx_state_q;
    case (rx_state_q)
      RX_IDLE:  if (push)   rx_state_d = RX_ACK;
      RX_ACK:               rx_state_d = RX_DRAIN;
      RX_DRAIN: if (!req_i) rx_state_d = RX_IDLE;
      default:              rx_state_d = RX_IDLE;
    endcase
  end

  // NOTE: the storage array has no reset; emptiness is tracked by count_q,
  // so stale contents are never presented as valid.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= flit_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_br_lite_local_if.sv
// Testbench for br_lite_local_if: directed steps plus randomized flits,
// checked against a transaction-level model (expected id counter and a
// queue of received flits).

module tb_br_lite_local_if;
  import br_lite_pkg::*;

  localparam logic [BR_ADDR_W-1:0] SEQ   = 16'h0003;
  localparam int                   DEPTH = 4;
  localparam int                   ID_MOD = 1 << BR_ID_W;

  logic                      clk_i = 1'b0;
  logic                      rst_i;
  logic                      tx_valid_i;
  logic                      tx_ready_o;
  logic [BR_SVC_W-1:0]       tx_service_i;
  logic [BR_ADDR_W-1:0]      tx_target_i;
  logic [BR_PAYLOAD_W-1:0]   tx_payload_i;
  logic                      tx_err_o;
  logic                      local_busy_i;
  br_data_t                  flit_o;
  logic                      req_o;
  logic                      ack_i;
  br_data_t                  flit_i;
  logic                      req_i;
  logic                      ack_o;
  logic                      rx_valid_o;
  logic                      rx_ready_i;
  br_data_t                  rx_flit_o;
  logic [$clog2(DEPTH):0]    rx_count_o;

  br_lite_local_if #(.SEQ_ADDRESS(SEQ), .RX_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .tx_service_i(tx_service_i), .tx_target_i(tx_target_i),
    .tx_payload_i(tx_payload_i), .tx_err_o(tx_err_o),
    .local_busy_i(local_busy_i), .flit_o(flit_o), .req_o(req_o), .ack_i(ack_i),
    .flit_i(flit_i), .req_i(req_i), .ack_o(ack_o),
    .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .rx_flit_o(rx_flit_o), .rx_count_o(rx_count_o)
  );

  always #5 clk_i = ~clk_i;

  int       checks   = 0;
  int       failures = 0;
  int       model_id = 0;
  br_data_t rxq[$];

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic br_data_t rand_flit();
    br_data_t f;
    f.seq_source = BR_ADDR_W'($urandom);
    f.seq_target = BR_ADDR_W'($urandom);
    f.service    = br_service_t'($urandom_range(0, 2));
    f.payload    = $urandom;
    f.id         = BR_ID_W'($urandom);
    return f;
  endfunction

  // One PE request, optionally held off by local_busy, acked by the
  // router model ack_delay cycles after req is first seen.
  task automatic tx_send(input br_service_t svc, input logic [15:0] tgt,
                         input logic [31:0] pl, input int busy_cycles,
                         input int ack_delay);
    br_data_t exp;
    tx_valid_i   = 1'b1;
    tx_service_i = svc;
    tx_target_i  = tgt;
    tx_payload_i = pl;
    for (int i = 0; i < busy_cycles; i++) begin
      local_busy_i = 1'b1;
      #1;
      check("tx_ready_while_busy", tx_ready_o, 1'b0);
      check("req_while_busy", req_o, 1'b0);
      step();
    end
    local_busy_i = 1'b0;
    #1;
    check("tx_ready_idle", tx_ready_o, 1'b1);
    step();
    tx_valid_i = 1'b0;
    if (svc == BR_SVC_CLEAR) begin
      check("tx_err_pulse", tx_err_o, 1'b1);
      check("req_after_clear", req_o, 1'b0);
      step();
      check("tx_err_one_cycle", tx_err_o, 1'b0);
      check("req_after_clear2", req_o, 1'b0);
    end else begin
      exp = '{seq_source: SEQ, seq_target: tgt, service: svc,
              payload: pl, id: BR_ID_W'(model_id)};
      model_id = (model_id + 1) % ID_MOD;
      check("req_raised", req_o, 1'b1);
      check("flit_out", flit_o, exp);
      check("tx_ready_in_req", tx_ready_o, 1'b0);
      for (int i = 0; i < ack_delay; i++) begin
        step();
        check("req_held", req_o, 1'b1);
        check("flit_held", flit_o, exp);
      end
      ack_i = 1'b1;
      step();
      ack_i = 1'b0;
      check("req_dropped_after_ack", req_o, 1'b0);
      check("flit_kept_idle", flit_o, exp);
      check("tx_err_quiet", tx_err_o, 1'b0);
    end
  endtask

  // Router model: req_i is already high; wait for one ack, then drop req.
  task automatic rx_wait_ack(input br_data_t f, input int budget);
    bit got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      step();
      if (ack_o) got = 1'b1;
    end
    check("rx_ack_seen", got, 1'b1);
    req_i = 1'b0;
    if (got) begin
      rxq.push_back(f);
      check("rx_count_after_push", rx_count_o, rxq.size());
    end
    step();
    check("rx_ack_one_cycle", ack_o, 1'b0);
    step();
  endtask

  task automatic rx_offer(input br_data_t f);
    flit_i = f;
    req_i  = 1'b1;
    rx_wait_ack(f, 8);
  endtask

  task automatic rx_pop();
    check("rx_valid", rx_valid_o, 1'b1);
    if (rxq.size() > 0) check("rx_order", rx_flit_o, rxq[0]);
    rx_ready_i = 1'b1;
    step();
    rx_ready_i = 1'b0;
    if (rxq.size() > 0) void'(rxq.pop_front());
    check("rx_count_after_pop", rx_count_o, rxq.size());
  endtask

  initial begin
    br_data_t f;
    rst_i = 1'b1; tx_valid_i = 1'b0; tx_service_i = '0; tx_target_i = '0;
    tx_payload_i = '0; local_busy_i = 1'b0; ack_i = 1'b0; flit_i = '0;
    req_i = 1'b0; rx_ready_i = 1'b0;

    // Reset state
    step(); step();
    check("rst_req", req_o, 1'b0);
    check("rst_ack", ack_o, 1'b0);
    check("rst_tx_err", tx_err_o, 1'b0);
    check("rst_rx_valid", rx_valid_o, 1'b0);
    check("rst_rx_count", rx_count_o, 0);
    check("rst_flit", flit_o, '0);
    rst_i = 1'b0;
    step();

    // 1: basic TX, ack two cycles after req, then a second request (id 1)
    tx_send(BR_SVC_TGT, 16'd5, 32'h0000_ABCD, 0, 2);
    tx_send(BR_SVC_ALL, 16'd9, 32'h1234_5678, 0, 1);

    // 2: local_busy holds off acceptance
    tx_send(BR_SVC_TGT, 16'd7, 32'hCAFE_0001, 3, 0);

    // 3: CLEAR is rejected, id unchanged on the following send
    tx_send(BR_SVC_CLEAR, 16'd1, 32'hDEAD_BEEF, 0, 0);
    tx_send(BR_SVC_TGT, 16'd2, 32'h0000_0002, 0, 0);

    // 4: fill RX FIFO, stall a 5th request, pop, order kept across wrap
    for (int i = 0; i < DEPTH; i++) rx_offer(rand_flit());
    check("rx_full_count", rx_count_o, DEPTH);
    f = rand_flit();
    flit_i = f;
    req_i  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rx_no_ack_full", ack_o, 1'b0);
      check("rx_full_hold", rx_count_o, DEPTH);
    end
    rx_pop();
    rx_wait_ack(f, 6);
    while (rxq.size() > 0) rx_pop();
    check("rx_empty", rx_valid_o, 1'b0);

    // 5: simultaneous push and pop at count 2
    rx_offer(rand_flit());
    rx_offer(rand_flit());
    check("rx_count_two", rx_count_o, 2);
    check("rx_head_before", rx_flit_o, rxq[0]);
    f = rand_flit();
    flit_i = f; req_i = 1'b1; rx_ready_i = 1'b1;
    step();
    rx_ready_i = 1'b0;
    void'(rxq.pop_front());
    rxq.push_back(f);
    check("rx_pushpop_ack", ack_o, 1'b1);
    check("rx_pushpop_count", rx_count_o, rxq.size());
    req_i = 1'b0;
    step(); step();
    while (rxq.size() > 0) rx_pop();

    // 5b: id wraps after 2^width sends (randomized requests and ack delays)
    for (int i = 0; i < ID_MOD + 3; i++)
      tx_send($urandom_range(0, 1) ? BR_SVC_TGT : BR_SVC_ALL,
              BR_ADDR_W'($urandom), $urandom, $urandom_range(0, 1),
              $urandom_range(0, 2));

    // 6: reset while req_o is high and the RX FSM is acking
    rx_offer(rand_flit());
    tx_valid_i = 1'b1; tx_service_i = BR_SVC_TGT;
    tx_target_i = 16'h0042; tx_payload_i = 32'h5555_AAAA;
    flit_i = rand_flit(); req_i = 1'b1;
    step();
    tx_valid_i = 1'b0;
    check("pre_rst_req", req_o, 1'b1);
    check("pre_rst_ack", ack_o, 1'b1);
    rst_i = 1'b1; req_i = 1'b0;
    step();
    check("mid_rst_req", req_o, 1'b0);
    check("mid_rst_ack", ack_o, 1'b0);
    check("mid_rst_count", rx_count_o, 0);
    check("mid_rst_valid", rx_valid_o, 1'b0);
    check("mid_rst_flit", flit_o, '0);
    rxq.delete();
    model_id = 0;
    rst_i = 1'b0;
    step();
    tx_send(BR_SVC_TGT, 16'd5, 32'h0000_0001, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard bound in case a handshake wedges outside a bounded loop.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
